// File: rtl/nn_fixed_pkg.sv
// Shared Q4.12 fixed-point types and constants for the neuron datapaths.
// Also holds the PLAN sigmoid breakpoints/offsets and the neuron FSM state type.
package nn_fixed_pkg;

    localparam int Q_W       = 16;
    localparam int FRAC_BITS = 12;
    localparam int ONE       = 4096;
    localparam int HALF      = 2048;

    // PLAN segment boundaries on |x|: 1.0, 2.375, 5.0
    localparam int PLAN_BP_LO  = 4096;
    localparam int PLAN_BP_MID = 9728;
    localparam int PLAN_BP_HI  = 20480;

    // PLAN segment offsets: 0.5, 0.625, 0.84375
    localparam int PLAN_OFS_LO  = 2048;
    localparam int PLAN_OFS_MID = 2560;
    localparam int PLAN_OFS_HI  = 3456;

    typedef logic signed [Q_W-1:0] q4_12_t;

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        ACTIVATE = 2'd1,
        HOLD     = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/forward_propper_if.sv
// Pair-input / result-output stream bundle of the forward neuron.
// Valid/ready: a beat transfers on a rising clock edge where valid && ready; valid must not depend on ready.
interface forward_propper_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_value;
    logic signed [DATA_W-1:0] in_weight;
    logic signed [DATA_W-1:0] in_bias;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_sum;
    logic signed [DATA_W-1:0] out_axon;

    modport master (
        output in_valid, in_value, in_weight, in_bias, out_ready,
        input  in_ready, out_valid, out_sum, out_axon
    );

    modport slave (
        input  in_valid, in_value, in_weight, in_bias, out_ready,
        output in_ready, out_valid, out_sum, out_axon
    );
endinterface

// File: rtl/sigmoid_plan.sv
// Combinational piecewise-linear (PLAN) sigmoid on Q4.12; output spans 0..4096.
// Shared with the back-propagation path, so it stays free of clocks and state.
module sigmoid_plan
    import nn_fixed_pkg::*;
(
    input  q4_12_t x,
    output q4_12_t y
);
    logic [Q_W-1:0] mag;
    logic [Q_W-1:0] y_pos;
    logic           neg;

    always_comb begin
        neg = x[Q_W-1];
        // -32768 has no positive twin in Q4.12, so it folds onto the largest magnitude
        if (x == {1'b1, {(Q_W-1){1'b0}}}) begin
            mag = {1'b0, {(Q_W-1){1'b1}}};
        end else if (neg) begin
            mag = Q_W'(-x);
        end else begin
            mag = Q_W'(x);
        end
    end

    always_comb begin
        if (mag >= Q_W'(PLAN_BP_HI)) begin
            y_pos = Q_W'(ONE);
        end else if (mag >= Q_W'(PLAN_BP_MID)) begin
            y_pos = (mag >> 5) + Q_W'(PLAN_OFS_HI);
        end else if (mag >= Q_W'(PLAN_BP_LO)) begin
            y_pos = (mag >> 3) + Q_W'(PLAN_OFS_MID);
        end else begin
            y_pos = (mag >> 2) + Q_W'(PLAN_OFS_LO);
        end
    end

    assign y = neg ? q4_12_t'(Q_W'(ONE) - y_pos) : q4_12_t'(y_pos);

endmodule

// File: rtl/forward_propper.sv
// Forward-pass neuron: serially accumulates N_INPUTS value*weight products plus bias,
// then saturates the sum to Q4.12 and presents it with its PLAN sigmoid axon.
module forward_propper
    import nn_fixed_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40
) (
    input  logic            clk,
    input  logic            rst,
    forward_propper_if.slave bus,
    output fsm_state_t      dbg_state,
    output logic [8:0]      dbg_count
);
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam int PROD_W = 2 * DATA_W;

    fsm_state_t state;
    fsm_state_t state_next;

    logic [CNT_W-1:0]        count;
    logic signed [ACC_W-1:0] acc;
    logic signed [DATA_W-1:0] bias;
    logic                    out_valid_q;
    logic signed [DATA_W-1:0] out_sum_q;
    logic signed [DATA_W-1:0] out_axon_q;

    logic                    in_ready;
    logic                    accept;
    logic                    last_beat;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  total;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] sum_sat;
    q4_12_t                   axon_next;

    assign last_beat = (count == CNT_W'(N_INPUTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (last_beat) begin
                        state_next = ACTIVATE;
                    end
                end
            end
            ACTIVATE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    assign prod     = bus.in_value * bus.in_weight;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W - DATA_W - FRAC_BITS){bias[DATA_W-1]}}, bias, {FRAC_BITS{1'b0}}};
    assign total    = acc + bias_ext;
    assign shifted  = total >>> FRAC_BITS;

    // The shifted sum fits Q4.12 only when every bit above the sign position agrees with it
    always_comb begin
        if (&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1]) begin
            sum_sat = shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            sum_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sum_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    sigmoid_plan u_sigmoid (
        .x (sum_sat),
        .y (axon_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            acc         <= '0;
            bias        <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_axon_q  <= '0;
        end else begin
            if (accept) begin
                // First beat restarts the sum so nothing leaks from the previous evaluation
                if (count == '0) begin
                    acc  <= prod_ext;
                    bias <= bus.in_bias;
                end else begin
                    acc <= acc + prod_ext;
                end
                count <= last_beat ? '0 : count + 1'b1;
            end
            if (state == ACTIVATE) begin
                out_sum_q   <= sum_sat;
                out_axon_q  <= axon_next;
                out_valid_q <= 1'b1;
            end else if (state == HOLD && out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_axon  = out_axon_q;

    assign dbg_state = state;
    assign dbg_count = 9'(count);

endmodule

// File: tb/tb_forward_propper.sv
// Bench for forward_propper: directed and random evaluations checked against a
// reference neuron model through an expected-result queue, plus stall and reset cases.
module tb_forward_propper;
    import nn_fixed_pkg::*;

    localparam int N_INPUTS = 4;
    localparam int DATA_W   = 16;
    localparam int ACC_W    = 40;

    logic       clk;
    logic       rst;
    fsm_state_t dbg_state;
    logic [8:0] dbg_count;

    forward_propper_if #(.DATA_W(DATA_W)) bus ();

    forward_propper #(
        .N_INPUTS (N_INPUTS),
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    int last_hs_cyc = 0;
    logic prev_ov = 1'b0;
    int val_a[N_INPUTS];
    int wt_a[N_INPUTS];

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int plan_ref(input int x);
        int a;
        int y;
        a = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
        if (a >= 20480)      y = 4096;
        else if (a >= 9728)  y = (a >> 5) + 3456;
        else if (a >= 4096)  y = (a >> 3) + 2560;
        else                 y = (a >> 2) + 2048;
        if (x < 0) y = 4096 - y;
        return y;
    endfunction

    function automatic logic [31:0] neuron_ref(input int b);
        longint acc;
        longint s;
        logic [15:0] s16;
        logic [15:0] a16;
        acc = longint'(b) * 4096;
        for (int i = 0; i < N_INPUTS; i++) acc += longint'(val_a[i]) * longint'(wt_a[i]);
        s = acc >>> 12;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        s16 = 16'(s);
        a16 = 16'(plan_ref(int'(s)));
        return {s16, a16};
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        logic signed [15:0] es;
        logic signed [15:0] ea;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) check_val("latency", cyc - last_hs_cyc, 2);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    es = e[31:16];
                    ea = e[15:0];
                    check_val("out_sum", bus.out_sum, es);
                    check_val("out_axon", bus.out_axon, ea);
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the beat transferred
    task automatic send_pair(input int v, input int w, input int b, input int max_gap);
        int g;
        int waited;
        g = $urandom_range(0, max_gap);
        if (g > 0) begin
            bus.in_valid = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_value  = 16'(v);
        bus.in_weight = 16'(w);
        bus.in_bias   = 16'(b);
        bus.in_valid  = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                last_hs_cyc = cyc;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                break;
            end
            waited++;
            if (waited > 200) begin
                check_val("in_handshake_timeout", 0, 1);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                break;
            end
        end
    endtask

    // Bias is meaningful only on beat 0; later beats carry noise that must be ignored
    task automatic run_eval(input int b, input int max_gap);
        exp_q.push_back(neuron_ref(b));
        for (int i = 0; i < N_INPUTS; i++)
            send_pair(val_a[i], wt_a[i], (i == 0) ? b : int'($urandom_range(0, 65535)) - 32768, max_gap);
    endtask

    task automatic fill(input int v, input int w);
        for (int i = 0; i < N_INPUTS; i++) begin
            val_a[i] = v;
            wt_a[i]  = w;
        end
    endtask

    task automatic wait_out_valid(input string tag);
        int waited;
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_valid) check_val(tag, 0, 1);
    endtask

    task automatic drain(input int budget);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check_val("drain_left", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic signed [15:0] es;
        logic signed [15:0] ea;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_weight = '0;
        bus.in_bias   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_sum", bus.out_sum, 0);
        check_val("rst_out_axon", bus.out_axon, 0);
        check_val("rst_state", int'(dbg_state), int'(ACCUM));
        check_val("rst_count", dbg_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed points from the activation curve
        fill(4096, 0);         run_eval(0, 0);      drain(50);
        fill(4096, 1024);      run_eval(0, 2);      drain(50);
        fill(4096, -1024);     run_eval(0, 2);      drain(50);
        fill(28672, 28672);    run_eval(0, 0);      drain(50);
        fill(28672, -28672);   run_eval(0, 1);      drain(50);
        fill(4096, 0);         run_eval(12288, 0);  drain(50);

        // Back-to-back random evaluations with input holes
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                val_a[i] = int'($urandom_range(0, 16384)) - 8192;
                wt_a[i]  = int'($urandom_range(0, 16384)) - 8192;
            end
            run_eval(int'($urandom_range(0, 16384)) - 8192, 3);
        end
        drain(200);

        // Output stall with the next pair already offered
        bus.out_ready = 1'b0;
        fill(4096, 2048);
        run_eval(-4096, 0);
        wait_out_valid("stall_out_timeout");
        es = exp_q[0][31:16];
        ea = exp_q[0][15:0];
        for (int i = 0; i < N_INPUTS; i++) begin
            val_a[i] = 8192 - i * 1000;
            wt_a[i]  = 1500 + i * 300;
        end
        bus.in_value  = 16'(val_a[0]);
        bus.in_weight = 16'(wt_a[0]);
        bus.in_bias   = 16'(700);
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_in_ready", bus.in_ready, 0);
            check_val("stall_out_valid", bus.out_valid, 1);
            check_val("stall_out_sum", bus.out_sum, es);
            check_val("stall_out_axon", bus.out_axon, ea);
            check_val("stall_count", dbg_count, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        run_eval(700, 0);
        drain(50);

        // Reset during accumulation, then a clean evaluation
        for (int i = 0; i < 2; i++) send_pair(30000, 30000, 16000, 3);
        check_val("mid_count", dbg_count, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_acc_count", dbg_count, 0);
        check_val("abort_acc_state", int'(dbg_state), int'(ACCUM));
        check_val("abort_acc_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill(2048, 3000);
        run_eval(-1000, 3);
        drain(50);

        // Reset while a result is held
        bus.out_ready = 1'b0;
        fill(8192, 4096);
        run_eval(0, 0);
        wait_out_valid("hold_out_timeout");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_hold_valid", bus.out_valid, 0);
        check_val("abort_hold_state", int'(dbg_state), int'(ACCUM));
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        fill(-6000, 5000);
        run_eval(2000, 1);
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
